decoder_addr_seq: RTL



---
 rtl/decoder_addr_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/decoder_addr_seq.sv
// Address sequencer feeding the 6-to-64 one-hot decoder tree: scans a latched address range
// with a per-address dwell time. Define DECODER_SEQ_PASS_CNT_EN to add the pass_cnt output.
module decoder_addr_seq #(
  parameter int AW      = 6,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [AW-1:0]      start_addr,
  input  logic [AW-1:0]      end_addr,
  input  logic               dir,
  input  logic               repeat_en,
  input  logic [DWELL_W-1:0] dwell,
  output logic [AW-1:0]      addr_o,
  output logic               en_o,
  output logic               busy,
  output logic               done,
  output logic               wrap_o
`ifdef DECODER_SEQ_PASS_CNT_EN
  ,
  output logic [7:0]         pass_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 en_q, en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wrap_q, wrap_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;

  // Range configuration captured at accept; later input changes must not disturb a scan.
  logic [AW-1:0]        start_cfg_q, start_cfg_d;
  logic [AW-1:0]        end_cfg_q, end_cfg_d;
  logic                 dir_cfg_q, dir_cfg_d;
  logic                 rep_cfg_q, rep_cfg_d;
  logic [DWELL_W-1:0]   dwell_cfg_q, dwell_cfg_d;

`ifdef DECODER_SEQ_PASS_CNT_EN
  logic [7:0]           pass_q, pass_d;
`endif

  // NOTE: every _d gets a default before the case, so no path leaves a latch behind.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    en_d        = en_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    wrap_d      = 1'b0;
    cnt_d       = cnt_q;
    start_cfg_d = start_cfg_q;
    end_cfg_d   = end_cfg_q;
    dir_cfg_d   = dir_cfg_q;
    rep_cfg_d   = rep_cfg_q;
    dwell_cfg_d = dwell_cfg_q;
`ifdef DECODER_SEQ_PASS_CNT_EN
    pass_d      = pass_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          start_cfg_d = start_addr;
          end_cfg_d   = end_addr;
          dir_cfg_d   = dir;
          rep_cfg_d   = repeat_en;
          dwell_cfg_d = dwell;
          addr_d      = start_addr;
          en_d        = 1'b1;
          busy_d      = 1'b1;
          cnt_d       = dwell;
          state_d     = S_RUN;
`ifdef DECODER_SEQ_PASS_CNT_EN
          pass_d      = 8'd0;
`endif
        end
      end

      S_RUN: begin
        if (stop) begin
          en_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (addr_q != end_cfg_q) begin
          // Address arithmetic wraps modulo 2**AW by construction.
          addr_d = dir_cfg_q ? addr_q - AW'(1) : addr_q + AW'(1);
          cnt_d  = dwell_cfg_q;
        end else begin
`ifdef DECODER_SEQ_PASS_CNT_EN
          if (pass_q != 8'hFF) pass_d = pass_q + 8'd1;
`endif
          if (rep_cfg_q) begin
            addr_d = start_cfg_q;
            cnt_d  = dwell_cfg_q;
            wrap_d = 1'b1;
          end else begin
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the config registers are reset too, so no X can leak from them after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
      cnt_q       <= '0;
      start_cfg_q <= '0;
      end_cfg_q   <= '0;
      dir_cfg_q   <= 1'b0;
      rep_cfg_q   <= 1'b0;
      dwell_cfg_q <= '0;
`ifdef DECODER_SEQ_PASS_CNT_EN
      pass_q      <= 8'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q     <= state_d;
      addr_q      <= addr_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wrap_q      <= wrap_d;
      cnt_q       <= cnt_d;
      start_cfg_q <= start_cfg_d;
      end_cfg_q   <= end_cfg_d;
      dir_cfg_q   <= dir_cfg_d;
      rep_cfg_q   <= rep_cfg_d;
      dwell_cfg_q <= dwell_cfg_d;
`ifdef DECODER_SEQ_PASS_CNT_EN
      pass_q      <= pass_d;
`endif
    end
  end

  assign addr_o = addr_q;
  assign en_o   = en_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign wrap_o = wrap_q;
`ifdef DECODER_SEQ_PASS_CNT_EN
  assign pass_cnt = pass_q;
`endif

endmodule
